// File: rtl/bus_arbiter_4_32b.sv
// 4-requester round-robin bus arbiter with a registered owner and a DATA_WIDTH output mux.
// 1-cycle grant latency; optional hold timeout under macro ARB_TIMEOUT_EN.
module bus_arbiter_4_32b #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [3:0]            last,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [7:0] HOLD_SAT = 8'(MAX_HOLD);

  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx, sel_nx, winner;
  logic [3:0] gnt_nx, others;
  logic       vld_nx, timeout;
  logic [7:0] hold, hold_nx;

  // Highest priority is base+1, lowest is base itself.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  assign timeout = (hold == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd3;
      sel       <= 2'd0;
      gnt       <= 4'b0000;
      out_valid <= 1'b0;
      hold      <= 8'd0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      sel       <= sel_nx;
      gnt       <= gnt_nx;
      out_valid <= vld_nx;
      hold      <= hold_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    gnt_nx   = gnt;
    vld_nx   = out_valid;
    hold_nx  = hold;
    others   = 4'b0000;
    winner   = 2'd0;
    case (state)
      IDLE: begin
        if (|req) begin
          winner   = rr_pick(req, ptr);
          state_nx = OWNED;
          sel_nx   = winner;
          gnt_nx   = 4'b0001 << winner;
          vld_nx   = 1'b1;
          hold_nx  = 8'd0;
        end
      end
      OWNED: begin
        hold_nx = (hold == HOLD_SAT) ? hold : hold + 8'd1;
        if (!req[sel] || last[sel] || timeout) begin
          ptr_nx = sel;
          // The releasing owner sits out one arbitration round.
          others = req & ~(4'b0001 << sel);
          if (|others) begin
            winner  = rr_pick(others, sel);
            sel_nx  = winner;
            gnt_nx  = 4'b0001 << winner;
            vld_nx  = 1'b1;
            hold_nx = 8'd0;
          end else begin
            state_nx = IDLE;
            gnt_nx   = 4'b0000;
            vld_nx   = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (sel)
        2'd0:    out_data = in0;
        2'd1:    out_data = in1;
        2'd2:    out_data = in2;
        default: out_data = in3;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_4_32b.sv
// Directed scoreboard bench for bus_arbiter_4_32b.
module tb_bus_arbiter_4_32b;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, last;
  logic [31:0] in0, in1, in2, in3;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic        out_valid;

  bus_arbiter_4_32b #(.DATA_WIDTH(32), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .gnt(gnt), .sel(sel), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [3:0] g;
    string      nm;
  } ent_t;

  ent_t        sb[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  logic [31:0] inv[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    enc = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) enc = 2'(i);
  endfunction

  // Drive one cycle of inputs; expected outputs follow the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [3:0] g, input string nm);
    ent_t e;
    @(negedge clk);
    req  = r;
    last = l;
    e.tag = cyc + 1;
    e.g   = g;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        chk({e.nm, "_cycle"}, 32'(cyc), 32'(e.tag));
        chk({e.nm, "_gnt"}, 32'(gnt), 32'(e.g));
        chk({e.nm, "_valid"}, 32'(out_valid), 32'(e.g != 4'b0000));
        if (e.g != 4'b0000) begin
          chk({e.nm, "_sel"}, 32'(sel), 32'(enc(e.g)));
          chk({e.nm, "_data"}, out_data, inv[enc(e.g)]);
        end else begin
          chk({e.nm, "_data"}, out_data, 32'h0);
        end
      end
    end
  end

  initial begin : stim
    logic [3:0] g;
    inv[0] = 32'h11111111; inv[1] = 32'h22222222;
    inv[2] = 32'h33333333; inv[3] = 32'h44444444;
    in0 = inv[0]; in1 = inv[1]; in2 = inv[2]; in3 = inv[3];
    rst = 1'b1; req = 4'b0000; last = 4'b0000;
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_data", out_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset priority then round-robin wrap with last pulses.
    step(4'b1111, 4'b0000, 4'b0001, "prio");
    step(4'b1111, 4'b0000, 4'b0001, "prio_hold");
    step(4'b1111, 4'b0001, 4'b0010, "rr1");
    step(4'b1111, 4'b0010, 4'b0100, "rr2");
    step(4'b1111, 4'b0100, 4'b1000, "rr3");
    step(4'b1111, 4'b1000, 4'b0001, "rr_wrap");
    step(4'b0000, 4'b0000, 4'b0000, "drop");
    step(4'b0000, 4'b0000, 4'b0000, "idle");

    // Single requester: release forces one idle cycle before regrant.
    step(4'b0100, 4'b0000, 4'b0100, "single");
    step(4'b0100, 4'b0100, 4'b0000, "single_rel");
    step(4'b0100, 4'b0000, 4'b0100, "single_again");
    step(4'b0100, 4'b0000, 4'b0100, "single_hold");
    step(4'b0000, 4'b0000, 4'b0000, "single_drop");

    // Two requesters held, no owner last; non-owner last is ignored.
    step(4'b0011, 4'b0000, 4'b0001, "hold_grant");
    for (int k = 2; k <= 24; k++) begin
`ifdef ARB_TIMEOUT_EN
      g = (((k - 1) / 8) % 2 == 1) ? 4'b0010 : 4'b0001;
`else
      g = 4'b0001;
`endif
      step(4'b0011, (k == 2) ? 4'b0010 : 4'b0000, g, "hold");
    end
    step(4'b0000, 4'b0000, 4'b0000, "hold_drop");

    // Async reset during a grant to requester 3.
    step(4'b1000, 4'b0000, 4'b1000, "r3_grant");
    step(4'b1000, 4'b0000, 4'b1000, "r3_hold");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data", out_data, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(4'b1000, 4'b0000, 4'b1000, "post_rst");
    step(4'b1000, 4'b1000, 4'b0000, "post_rst_rel");
    step(4'b0000, 4'b0000, 4'b0000, "end_idle");

    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_4_32b.md
BUS_ARBITER_4_32B -- requirements
Module: bus_arbiter_4_32b

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each requester data port and of out_data.
REQ-002 SHALL have parameter MAX_HOLD, default 8, the maximum number of cycles one grant may last; range 2..255.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, 4, per-requester bus request; bit i belongs to requester i.
REQ-006 SHALL have port last, input, 4, per-requester release strobe; it is honoured only from the current owner.
REQ-007 SHALL have ports in0, in1, in2, in3, input, DATA_WIDTH each, the requester data.
REQ-008 SHALL have port gnt, output, 4, one-hot grant, or all-zero when no requester owns the bus.
REQ-009 SHALL have port sel, output, 2, the registered owner index that drives the 4-way 32-bit datapath mux select.
REQ-010 SHALL have port out_data, output, DATA_WIDTH, the data of the selected input.
REQ-011 SHALL have port out_valid, output, 1, high exactly when gnt is non-zero.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no owner) and OWNED (gnt one-hot).
REQ-013 SHALL, in IDLE with req non-zero, pick the winner in round-robin order and enter OWNED on the next edge with gnt, sel and out_valid registered together; arbitration latency is 1 cycle.
REQ-014 SHALL search round-robin starting at (ptr+1) mod 4 and wrap 3->0, where ptr is the index of the most recent owner.
REQ-015 SHALL, in IDLE with req equal to 0, stay in IDLE with gnt=0 and out_valid=0.
REQ-016 SHALL release the owner at the end of any OWNED cycle in which req[owner]=0 or last[owner]=1.
REQ-017 SHALL, on release, set ptr to the owner index.
REQ-018 SHALL, on release with any other req bit set (excluding the owner), grant the next round-robin winner on the following edge with no IDLE bubble.
REQ-019 SHALL, on release with no other req bit set, enter IDLE even if the releasing owner still asserts req; that owner may win again one cycle later.
REQ-020 SHALL ignore last bits and req changes from non-owners while in OWNED.
REQ-021 SHALL never assert more than one gnt bit; gnt SHALL be 0 in IDLE.
REQ-022 SHALL drive out_data as in[sel] when out_valid=1 and all-zero otherwise, combinationally from the registered sel.
REQ-023 SHALL have a hold counter that clears on every new grant and increments each OWNED cycle, saturating at MAX_HOLD.

Reset
REQ-024 SHALL, while rst=1 and regardless of clk, force state=IDLE, gnt=0, sel=0, out_valid=0, out_data=0, hold counter=0 and ptr=3, so that requester 0 has first priority after reset.
REQ-025 SHALL, on reset asserted mid-grant, drop gnt immediately and, after deassertion, arbitrate afresh from ptr=3.

Configuration
REQ-026 SHALL, with macro ARB_TIMEOUT_EN defined, force a release at the end of the MAX_HOLD-th consecutive OWNED cycle of one grant, apply REQ-017 and REQ-018, and treat the owner as a normal requester afterward.
REQ-027 SHALL, with ARB_TIMEOUT_EN undefined, hold a grant until REQ-016 only; the hold counter SHALL then not affect behaviour and may be removed.

Verification
REQ-028 SHALL cover reset priority: after rst, req=4'b1111 with last=0 -> gnt=4'b0001, sel=0 one cycle later; out_data equals in0.
REQ-029 SHALL cover round-robin wrap: req=4'b1111 held, owner pulses last each grant -> gnt sequence 0001,0010,0100,1000,0001 with no idle cycles.
REQ-030 SHALL cover single-requester behaviour: req=4'b0100 held and last pulsed -> gnt=0100, then one IDLE cycle (gnt=0, out_data=0), then gnt=0100 again.
REQ-031 SHALL cover the timeout with ARB_TIMEOUT_EN and MAX_HOLD=8: req=4'b0011 held, no last -> gnt=0001 for exactly 8 cycles, then 0010 for 8, repeating; without the macro gnt stays at 0001 indefinitely.
REQ-032 SHALL cover async reset: rst pulsed mid-cycle during gnt=1000 -> gnt=0 and out_valid=0 before the next clk edge; after release with req=4'b1000 -> gnt=1000 one cycle later.
REQ-033 SHALL cover data steering: in0..in3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 with each requester granted in turn -> out_data matches in[sel] every OWNED cycle, checked at each edge with 0 mismatches.
